// File: rtl/ifu_pkg.sv
// Shared types and widths for the IFU memory-port arbiter.
package ifu_pkg;

  localparam int unsigned TAG_WIDTH  = 8;
  localparam int unsigned LINE_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ifu_arb_state_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [LINE_WIDTH-1:0] line;
    logic                  is_pf;
  } ifu_mem_rsp_t;

endpackage

// File: rtl/ifu_arb_timer.sv
// Response-wait timer: cleared while not waiting, counts while waiting,
// flags the last cycle of the wait window.
module ifu_arb_timer #(
  parameter int unsigned CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire_c
);

  localparam int unsigned TW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(CYCLES - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Next count: clear has priority over counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = count_q + TW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c = count_en && (count_q == LAST);

endmodule

// File: rtl/ifu_mem_arbiter.sv
// Shares the IFU memory port between demand misses and next-line prefetch:
// one transaction in flight, demand first, timeout with bounded re-issue.
module ifu_mem_arbiter
  import ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned PF_ENABLE      = 1
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [TAG_WIDTH-1:0]  dmd_reqTagIn,
  input  logic                  dmd_reqValidIn,
  input  logic [TAG_WIDTH-1:0]  pf_reqTagIn,
  input  logic                  pf_reqValidIn,
  output logic                  pf_reqReadyOut,
  output logic [TAG_WIDTH-1:0]  mem_reqTagOut,
  output logic                  mem_reqValidOut,
  input  logic                  mem_reqReadyIn,
  input  logic [TAG_WIDTH-1:0]  mem_rspTagIn,
  input  logic [LINE_WIDTH-1:0] mem_rspInsLineIn,
  input  logic                  mem_rspValidIn,
  output logic [TAG_WIDTH-1:0]  cache_rspTagOut,
  output logic [LINE_WIDTH-1:0] cache_rspLineOut,
  output logic                  cache_rspValidOut,
  output logic                  cache_rspIsPfOut,
  output logic                  busyOut,
  output logic                  timeoutErrOut
);

  localparam int unsigned   RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic          PF_ON       = (PF_ENABLE != 0);

  ifu_arb_state_t       state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 is_pf_q, is_pf_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic                 req_valid_q, req_valid_d;
  logic                 pf_ready_q, pf_ready_d;
  ifu_mem_rsp_t         rsp_q, rsp_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic timer_expire_c;
  logic dmd_echo_c;
  logic dmd_go_c;
  logic pf_go_c;
  logic rsp_match_c;
  logic promote_c;

  ifu_arb_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (Clock),
    .rst      (Rst),
    .clear    (state_q != WAIT),
    .count_en (state_q == WAIT),
    .expire_c (timer_expire_c)
  );

  // Request qualification: a demand for the line being delivered right now is an echo.
  always_comb begin
    dmd_echo_c  = rsp_valid_q && (dmd_reqTagIn == rsp_q.tag);
    dmd_go_c    = dmd_reqValidIn && !dmd_echo_c;
    pf_go_c     = PF_ON && pf_reqValidIn;
    rsp_match_c = mem_rspValidIn && (mem_rspTagIn == tag_q);
    promote_c   = dmd_reqValidIn && (dmd_reqTagIn == tag_q) && is_pf_q;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    is_pf_d     = is_pf_q;
    retry_d     = retry_q;
    req_valid_d = req_valid_q;
    pf_ready_d  = 1'b0;
    rsp_d       = rsp_q;
    rsp_valid_d = 1'b0;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        retry_d     = '0;
        req_valid_d = 1'b0;
        if (dmd_go_c) begin
          tag_d       = dmd_reqTagIn;
          is_pf_d     = 1'b0;
          req_valid_d = 1'b1;
          state_d     = REQ;
          // Prefetch of the same line is redundant: consume and drop it.
          if (pf_go_c && (pf_reqTagIn == dmd_reqTagIn)) begin
            pf_ready_d = 1'b1;
          end
        end else if (pf_go_c) begin
          tag_d       = pf_reqTagIn;
          is_pf_d     = 1'b1;
          pf_ready_d  = 1'b1;
          req_valid_d = 1'b1;
          state_d     = REQ;
        end
      end

      REQ: begin
        req_valid_d = 1'b1;
        if (mem_reqReadyIn) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        req_valid_d = 1'b0;
        if (promote_c) begin
          is_pf_d = 1'b0;
        end
        if (rsp_match_c) begin
          rsp_d.tag   = mem_rspTagIn;
          rsp_d.line  = mem_rspInsLineIn;
          rsp_d.is_pf = is_pf_q && !promote_c;
          rsp_valid_d = 1'b1;
          retry_d     = '0;
          state_d     = IDLE;
        end else if (timer_expire_c) begin
          if (retry_q < RETRY_LIMIT) begin
            retry_d     = retry_q + RW'(1);
            req_valid_d = 1'b1;
            state_d     = REQ;
          end else begin
            err_d   = 1'b1;
            retry_d = '0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        req_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      is_pf_q     <= 1'b0;
      retry_q     <= '0;
      req_valid_q <= 1'b0;
      pf_ready_q  <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      is_pf_q     <= is_pf_d;
      retry_q     <= retry_d;
      req_valid_q <= req_valid_d;
      pf_ready_q  <= pf_ready_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign pf_reqReadyOut    = pf_ready_q;
  assign mem_reqTagOut     = tag_q;
  assign mem_reqValidOut   = req_valid_q;
  assign cache_rspTagOut   = rsp_q.tag;
  assign cache_rspLineOut  = rsp_q.line;
  assign cache_rspValidOut = rsp_valid_q;
  assign cache_rspIsPfOut  = rsp_q.is_pf;
  assign busyOut           = busy_q;
  assign timeoutErrOut     = err_q;

endmodule
